// File: rtl/systemfinal_pio_in_irq.sv
// Avalon-MM input port: synchronised status bus with per-bit edge capture,
// interrupt mask and a registered IRQ output for the HPS lightweight bridge.
module systemfinal_pio_in_irq #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0,
    parameter int IRQ_MODE    = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             chipselect,
    input  logic [1:0]       address,
    input  logic             write,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_CONFIG  = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam logic [2:0] WARM_LOAD = 3'(SYNC_STAGES + 1);

    localparam logic [31:0] CONFIG_WORD = {21'd0, 1'(IRQ_MODE), 2'(EDGE_TYPE), 8'(WIDTH)};

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] data_sync;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] irqmask_q;
    logic [WIDTH-1:0] edgecap_q;
    logic [2:0]       warm_cnt_q;

    logic             warm_done;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_det;
    logic             wr_en;
    logic [WIDTH-1:0] edge_clr;
    logic [31:0]      rd_next;
    logic             irq_next;
    logic             unused_wdata;

    assign data_sync    = sync_q[SYNC_STAGES-1];
    assign warm_done    = (warm_cnt_q == 3'd0);
    assign wr_en        = chipselect & write;
    assign unused_wdata = ^writedata;

    // Synchroniser chain, previous-value register and warm-up counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_q     <= '0;
            warm_cnt_q <= WARM_LOAD;
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= data_sync;
            if (!warm_done) begin
                warm_cnt_q <= warm_cnt_q - 3'd1;
            end
        end
    end

    // Edges are ignored until the chain has flushed, so inputs already high
    // when reset releases do not look like fresh transitions.
    always_comb begin
        rise     = data_sync & ~prev_q;
        fall     = ~data_sync & prev_q;
        edge_det = '0;
        if (warm_done) begin
            case (EDGE_TYPE)
                0:       edge_det = rise;
                1:       edge_det = fall;
                default: edge_det = rise | fall;
            endcase
        end
    end

    always_comb begin
        edge_clr = '0;
        if (wr_en && address == ADDR_EDGECAP) begin
            edge_clr = writedata[WIDTH-1:0];
        end
    end

    // Set is OR-ed in after the clear so a coincident edge is never lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            edgecap_q <= '0;
            irqmask_q <= '0;
        end else begin
            edgecap_q <= (edgecap_q & ~edge_clr) | edge_det;
            if (wr_en && address == ADDR_IRQMASK) begin
                irqmask_q <= writedata[WIDTH-1:0];
            end
        end
    end

    always_comb begin
        rd_next = 32'd0;
        case (address)
            ADDR_DATA:    rd_next = 32'(data_sync);
            ADDR_CONFIG:  rd_next = CONFIG_WORD;
            ADDR_IRQMASK: rd_next = 32'(irqmask_q);
            ADDR_EDGECAP: rd_next = 32'(edgecap_q);
            default:      rd_next = 32'd0;
        endcase
    end

    always_comb begin
        if (IRQ_MODE == 1) begin
            irq_next = |(data_sync & irqmask_q);
        end else begin
            irq_next = |(edgecap_q & irqmask_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= 32'd0;
            irq      <= 1'b0;
        end else begin
            readdata <= rd_next;
            irq      <= irq_next;
        end
    end

endmodule

// File: tb/tb_systemfinal_pio_in_irq.sv
// Directed bench for systemfinal_pio_in_irq: four instances cover the default
// build, falling-edge capture, level IRQ mode and a 32-bit, 3-stage build.
module tb_systemfinal_pio_in_irq;

    logic        clk = 1'b0;
    logic        reset;
    logic        chipselect;
    logic [1:0]  address;
    logic        write;
    logic [31:0] writedata;

    logic [7:0]  in_port0, in_port1, in_port2;
    logic [31:0] in_port3;
    logic [31:0] rd0, rd1, rd2, rd3;
    logic        irq0, irq1, irq2, irq3;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    // Clock / reset
    always #5 clk = ~clk;

    systemfinal_pio_in_irq #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_MODE(0)) u_rise (
        .clk(clk), .reset(reset), .chipselect(chipselect), .address(address), .write(write),
        .writedata(writedata), .in_port(in_port0), .readdata(rd0), .irq(irq0));

    systemfinal_pio_in_irq #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(1), .IRQ_MODE(0)) u_fall (
        .clk(clk), .reset(reset), .chipselect(chipselect), .address(address), .write(write),
        .writedata(writedata), .in_port(in_port1), .readdata(rd1), .irq(irq1));

    systemfinal_pio_in_irq #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_MODE(1)) u_level (
        .clk(clk), .reset(reset), .chipselect(chipselect), .address(address), .write(write),
        .writedata(writedata), .in_port(in_port2), .readdata(rd2), .irq(irq2));

    systemfinal_pio_in_irq #(.WIDTH(32), .SYNC_STAGES(3), .EDGE_TYPE(0), .IRQ_MODE(0)) u_wide (
        .clk(clk), .reset(reset), .chipselect(chipselect), .address(address), .write(write),
        .writedata(writedata), .in_port(in_port3), .readdata(rd3), .irq(irq3));

    // Driver tasks: inputs change 1 ns after the rising edge, outputs are
    // sampled at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic bus_read(input logic [1:0] a);
        chipselect = 1'b1;
        write      = 1'b0;
        address    = a;
        tick();
        chipselect = 1'b0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write      = 1'b1;
        address    = a;
        writedata  = d;
        tick();
        chipselect = 1'b0;
        write      = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    initial begin
        reset      = 1'b1;
        chipselect = 1'b0;
        address    = 2'd0;
        write      = 1'b0;
        writedata  = 32'd0;
        in_port0   = 8'hFF;
        in_port1   = 8'h00;
        in_port2   = 8'h00;
        in_port3   = 32'd0;

        // T1: reset with inputs high, no edge after warm-up
        ticks(2);
        check("rst_rd0", rd0, 32'd0);
        check("rst_irq0", {31'd0, irq0}, 32'd0);
        check("rst_rd3", rd3, 32'd0);
        reset = 1'b0;
        ticks(6);
        check("t1_irq", {31'd0, irq0}, 32'd0);
        bus_read(2'd3);
        check("t1_edgecap", rd0, 32'd0);
        bus_read(2'd0);
        check("t1_data", rd0, 32'h0000_00FF);
        bus_read(2'd1);
        check("t1_cfg_rise", rd0, 32'h0000_0008);
        check("t1_cfg_fall", rd1, 32'h0000_0108);
        check("t1_cfg_level", rd2, 32'h0000_0408);
        check("t1_cfg_wide", rd3, 32'h0000_0020);

        // T2: rising edges captured, masked irq, W1C
        in_port0 = 8'h00;
        ticks(4);
        bus_write(2'd2, 32'h0000_0004);
        bus_read(2'd3);
        check("t2_no_fall", rd0, 32'd0);
        in_port0 = 8'h05;
        ticks(3);
        check("t2_irq_early", {31'd0, irq0}, 32'd0);
        tick();
        check("t2_irq_set", {31'd0, irq0}, 32'd1);
        bus_read(2'd3);
        check("t2_edgecap", rd0, 32'h0000_0005);
        bus_write(2'd3, 32'h0000_0004);
        tick();
        check("t2_irq_clr", {31'd0, irq0}, 32'd0);
        bus_read(2'd3);
        check("t2_w1c", rd0, 32'h0000_0001);
        bus_read(2'd2);
        check("t2_mask", rd0, 32'h0000_0004);

        // T3: edge and W1C of bit0 in the same clock, set wins
        in_port0 = 8'h04;
        ticks(4);
        bus_read(2'd3);
        check("t3_pre", rd0, 32'h0000_0001);
        in_port0 = 8'h05;
        ticks(2);
        bus_write(2'd3, 32'h0000_0001);
        bus_read(2'd3);
        check("t3_set_wins", rd0, 32'h0000_0001);
        bus_write(2'd3, 32'h0000_0001);
        bus_read(2'd3);
        check("t3_clear", rd0, 32'd0);

        // T4: falling-edge instance
        in_port1 = 8'h0F;
        ticks(4);
        bus_read(2'd3);
        check("t4_rise_ignored", rd1, 32'd0);
        in_port1 = 8'h00;
        ticks(4);
        bus_read(2'd3);
        check("t4_fall", rd1, 32'h0000_000F);
        bus_write(2'd3, 32'h0000_000F);
        in_port1 = 8'h0F;
        ticks(4);
        bus_read(2'd3);
        check("t4_rise_again", rd1, 32'd0);

        // T5: level irq follows in_port2[7] delayed by SYNC_STAGES+1
        bus_write(2'd2, 32'h0000_0080);
        tick();
        for (int k = 1; k <= 16; k++) exp_q.push_back((k >= 3 && k <= 12) ? 32'd1 : 32'd0);
        in_port2 = 8'h80;
        for (int k = 1; k <= 16; k++) begin
            tick();
            check($sformatf("t5_irq_k%0d", k), {31'd0, irq2}, exp_q.pop_front());
            if (k == 10) in_port2 = 8'h00;
        end
        bus_read(2'd3);
        check("t5_edgecap", rd2, 32'h0000_0080);
        check("t5_irq_after", {31'd0, irq2}, 32'd0);

        // T6: wide instance, reset mid-capture, writes to RO registers
        in_port3 = 32'hA000_0001;
        ticks(6);
        bus_read(2'd3);
        check("t6_edgecap", rd3, 32'hA000_0001);
        bus_write(2'd2, 32'h8000_0000);
        tick();
        check("t6_irq", {31'd0, irq3}, 32'd1);
        reset = 1'b1;
        tick();
        check("t6_rst_rd", rd3, 32'd0);
        check("t6_rst_irq", {31'd0, irq3}, 32'd0);
        reset = 1'b0;
        bus_read(2'd3);
        check("t6_rst_edgecap", rd3, 32'd0);
        bus_read(2'd2);
        check("t6_rst_mask", rd3, 32'd0);
        ticks(8);
        bus_read(2'd3);
        check("t6_warm_no_edge", rd3, 32'd0);
        bus_write(2'd0, 32'h0000_1234);
        bus_write(2'd1, 32'hFFFF_FFFF);
        bus_read(2'd0);
        check("t6_data_ro", rd3, 32'hA000_0001);
        bus_read(2'd1);
        check("t6_cfg_ro", rd3, 32'h0000_0020);

        // Final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
